// File: rtl/alt_reset_seq_delay_if.sv
// Bundle of per-channel ready, delay configuration and loss-count signals
// exchanged between the reset-sequencing delay block and its client.
interface alt_reset_seq_delay_if #(
    parameter int NUM_CH    = 4,
    parameter int CNTR_BITS = 16,
    parameter int LOSS_BITS = 8
);
    logic [NUM_CH-1:0]           ready_in;
    logic [NUM_CH*CNTR_BITS-1:0] delay_cfg;
    logic                        clr_loss;
    logic [NUM_CH-1:0]           ready_out;
    logic                        all_ready;
    logic [NUM_CH*LOSS_BITS-1:0] loss_cnt;

    modport master (
        output ready_in,
        output delay_cfg,
        output clr_loss,
        input  ready_out,
        input  all_ready,
        input  loss_cnt
    );

    modport slave (
        input  ready_in,
        input  delay_cfg,
        input  clr_loss,
        output ready_out,
        output all_ready,
        output loss_cnt
    );
endinterface

// File: rtl/alt_reset_seq_delay.sv
// Multi-channel reset-release delay: each ready output drops at once with its
// input, and re-asserts only after synchronisation plus a programmable delay.
module alt_reset_seq_delay #(
    parameter int NUM_CH      = 4,
    parameter int CNTR_BITS   = 16,
    parameter int SYNC_STAGES = 3,
    parameter int SEQUENTIAL  = 0,
    parameter int LOSS_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alt_reset_seq_delay_if.slave bus
);
    logic [NUM_CH-1:0] rdy;
    logic              all_ready_q;

    assign bus.ready_out = rdy;
    assign bus.all_ready = all_ready_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic                   chain_rst_n;
        logic                   cnt_rst_n;
        logic                   gate;
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNTR_BITS-1:0]   cfg;
        logic [CNTR_BITS-1:0]   cnt;
        logic                   rdy_q;
        logic                   rdy_d;
        logic [LOSS_BITS-1:0]   loss_q;

        assign cfg         = bus.delay_cfg[i*CNTR_BITS +: CNTR_BITS];
        assign chain_rst_n = rst_n & bus.ready_in[i];
        // A low ready_in ripples through the synchroniser straight into the
        // counter reset, so the output drops without waiting for a clock.
        assign cnt_rst_n   = rst_n & sync_q[SYNC_STAGES-1];

        if (SEQUENTIAL == 0 || i == 0) begin : g_free
            assign gate = 1'b1;
        end else begin : g_chain
            assign gate = rdy[i-1];
        end

        always_ff @(posedge clk or negedge chain_rst_n) begin
            if (!chain_rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            end
        end

        // Count only below the terminal value, so an all-ones delay never wraps.
        always_ff @(posedge clk or negedge cnt_rst_n) begin
            if (!cnt_rst_n) begin
                cnt   <= '0;
                rdy_q <= 1'b0;
            end else if (!gate) begin
                cnt   <= '0;
                rdy_q <= 1'b0;
            end else if (!rdy_q) begin
                if (cnt >= cfg) begin
                    rdy_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNTR_BITS'(1);
                end
            end
        end

        assign rdy[i] = rdy_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdy_d  <= 1'b0;
                loss_q <= '0;
            end else begin
                rdy_d <= rdy_q;
                if (bus.clr_loss) begin
                    loss_q <= '0;
                end else if (rdy_d && !rdy_q && (loss_q != '1)) begin
                    loss_q <= loss_q + LOSS_BITS'(1);
                end
            end
        end

        assign bus.loss_cnt[i*LOSS_BITS +: LOSS_BITS] = loss_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &rdy;
        end
    end
endmodule
